// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       iord;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM controller for a multicycle MIPS-subset datapath, with the
// combinational ALU decoder, PC enable and illegal-instruction pulse.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2, MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       memwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       branch;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  function automatic ctl_t decode_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BEQEX:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:  c.regwrite = 1'b1;
      JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t cur, nxt;
  ctl_t   ctl;
  logic   op_ok, funct_ok;

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      end
      // op is read straight from the external IR, which holds it stable
      MEMADR:  nxt = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  // Control word is registered from the next state, so it always matches cur
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= FETCH;
      ctl <= decode_ctl(FETCH);
    end else begin
      cur <= nxt;
      ctl <= decode_ctl(nxt);
    end
  end

  always_comb begin
    bus.alucontrol = 3'b010;
    case (ctl.aluop)
      2'b00: bus.alucontrol = 3'b010;
      2'b01: bus.alucontrol = 3'b110;
      default: begin
        case (bus.funct)
          6'b100000: bus.alucontrol = 3'b010;
          6'b100010: bus.alucontrol = 3'b110;
          6'b100100: bus.alucontrol = 3'b000;
          6'b100101: bus.alucontrol = 3'b001;
          6'b101010: bus.alucontrol = 3'b111;
          default:   bus.alucontrol = 3'b010;
        endcase
      end
    endcase
  end

  always_comb begin
    op_ok    = (bus.op == OP_RTYPE) || (bus.op == OP_LW) || (bus.op == OP_SW) ||
               (bus.op == OP_BEQ) || (bus.op == OP_ADDI) || (bus.op == OP_J);
    funct_ok = (bus.funct == 6'b100000) || (bus.funct == 6'b100010) ||
               (bus.funct == 6'b100100) || (bus.funct == 6'b100101) ||
               (bus.funct == 6'b101010);
  end

  assign bus.illegal  = (cur == DECODE) && (!op_ok || ((bus.op == OP_RTYPE) && !funct_ok));
  assign bus.pcen     = ctl.pcwrite | (ctl.branch & bus.zero);
  assign bus.irwrite  = ctl.irwrite;
  assign bus.memwrite = ctl.memwrite;
  assign bus.iord     = ctl.iord;
  assign bus.regwrite = ctl.regwrite;
  assign bus.regdst   = ctl.regdst;
  assign bus.memtoreg = ctl.memtoreg;
  assign bus.alusrca  = ctl.alusrca;
  assign bus.alusrcb  = ctl.alusrcb;
  assign bus.pcsrc    = ctl.pcsrc;
  assign bus.state    = cur;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model gives
// the expected state walk and per-state outputs, checked every cycle.
module tb_multicycle_controller;
  logic clk;
  logic reset;
  multicycle_controller_if bus ();

  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int exp_state = 0;
  bit chk_en = 1'b0;
  int seq[$];

  // Expected outputs of a state, from the per-state table, ALU decoder rules
  // and the illegal rule. Packing:
  // {pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca,
  //  alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], illegal}
  function automatic logic [15:0] model(int s, logic [5:0] op, logic [5:0] funct, logic zero);
    logic pcw, br, ir, mw, io, rw, rd, mr, sa, ill;
    logic [1:0] sb, ps, aluop;
    logic [2:0] alu;
    bit op_ok, f_ok;
    pcw = 0; br = 0; ir = 0; mw = 0; io = 0; rw = 0; rd = 0; mr = 0; sa = 0; ill = 0;
    sb = 0; ps = 0; aluop = 0;
    op_ok = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) ||
            (op == 6'd8) || (op == 6'd2);
    f_ok  = (funct == 6'd32) || (funct == 6'd34) || (funct == 6'd36) ||
            (funct == 6'd37) || (funct == 6'd42);
    case (s)
      0:  begin ir = 1; pcw = 1; sb = 2'd1; end
      1:  begin sb = 2'd3; ill = !op_ok || (op == 6'd0 && !f_ok); end
      2:  begin sa = 1; sb = 2'd2; end
      3:  io = 1;
      4:  begin mr = 1; rw = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin sa = 1; aluop = 2'd2; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; aluop = 2'd1; ps = 2'd1; br = 1; end
      9:  begin sa = 1; sb = 2'd2; end
      10: rw = 1;
      11: begin ps = 2'd2; pcw = 1; end
      default: ;
    endcase
    if (aluop == 2'd0)      alu = 3'd2;
    else if (aluop == 2'd1) alu = 3'd6;
    else case (funct)
      6'd34:   alu = 3'd6;
      6'd36:   alu = 3'd0;
      6'd37:   alu = 3'd1;
      6'd42:   alu = 3'd7;
      default: alu = 3'd2;
    endcase
    return {pcw | (br & zero), ir, mw, io, rw, rd, mr, sa, sb, ps, alu, ill};
  endfunction

  // Instruction walk through the state codes, derived from the opcode alone
  task automatic build_seq(input logic [5:0] op);
    case (op)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000010: seq = '{0, 1, 11};
      default:   seq = '{0, 1};
    endcase
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [15:0] act, exp;
      check("state", int'(bus.state), exp_state);
      exp = model(exp_state, bus.op, bus.funct, bus.zero);
      act = {bus.pcen, bus.irwrite, bus.memwrite, bus.iord, bus.regwrite, bus.regdst,
             bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal};
      checks++;
      if (act === exp) passed++;
      else $display("FAIL outputs state=%0d: got %b, required %b at %0t", exp_state, act, exp, $time);
    end
  end

  // Entered at posedge+1 of a FETCH cycle; leaves at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                           input int len, input int st2, input int alu2, input int pcen2,
                           input int ill);
    bus.op = op; bus.funct = funct; bus.zero = zero;
    build_seq(op);
    check("length", seq.size(), len);
    for (int i = 0; i < seq.size(); i++) begin
      exp_state = seq[i];
      if (i == 1) check("illegal_lit", int'(bus.illegal), ill);
      if (i == 2) begin
        check("state_lit", int'(bus.state), st2);
        check("alucontrol_lit", int'(bus.alucontrol), alu2);
        check("pcen_lit", int'(bus.pcen), pcen2);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
    exp_state = 0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //        op          funct       z   len st2 alu pcen ill
    run_instr(6'b100011, 6'b000000, 1'b1, 5, 2,  2,  0,  0);  // lw
    run_instr(6'b101011, 6'b000000, 1'b1, 4, 2,  2,  0,  0);  // sw
    run_instr(6'b000000, 6'b101010, 1'b1, 4, 6,  7,  0,  0);  // slt
    run_instr(6'b000000, 6'b100000, 1'b0, 4, 6,  2,  0,  0);  // add
    run_instr(6'b000000, 6'b100010, 1'b0, 4, 6,  6,  0,  0);  // sub
    run_instr(6'b000000, 6'b100100, 1'b1, 4, 6,  0,  0,  0);  // and
    run_instr(6'b000000, 6'b100101, 1'b0, 4, 6,  1,  0,  0);  // or
    run_instr(6'b000000, 6'b000111, 1'b0, 4, 6,  2,  0,  1);  // bad funct
    run_instr(6'b000100, 6'b000000, 1'b1, 3, 8,  6,  1,  0);  // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 3, 8,  6,  0,  0);  // beq not taken
    run_instr(6'b001000, 6'b000000, 1'b1, 4, 9,  2,  0,  0);  // addi
    run_instr(6'b000010, 6'b000000, 1'b0, 3, 11, 2,  1,  0);  // j
    run_instr(6'b111111, 6'b000000, 1'b1, 2, 0,  0,  0,  1);  // illegal op
    run_instr(6'b000001, 6'b101010, 1'b0, 2, 0,  0,  0,  1);  // illegal op

    // Reset asserted in the middle of MEMRD of a lw
    bus.op = 6'b100011; bus.zero = 1'b0;
    exp_state = 0;
    @(posedge clk); #1 exp_state = 1;
    @(posedge clk); #1 exp_state = 2;
    @(posedge clk); #1 exp_state = 3;
    #2 reset = 1'b1;
    exp_state = 0;
    #1;
    check("rst_state", int'(bus.state), 0);
    check("rst_irwrite", int'(bus.irwrite), 1);
    check("rst_memwrite", int'(bus.memwrite), 0);
    check("rst_regwrite", int'(bus.regwrite), 0);
    @(posedge clk); #1;
    check("rst_hold_state", int'(bus.state), 0);
    #2 reset = 1'b0;
    @(posedge clk); #1 exp_state = 1;
    @(posedge clk); #1 exp_state = 2;
    @(posedge clk); #1 exp_state = 3;
    @(posedge clk); #1 exp_state = 4;
    @(posedge clk); #1 exp_state = 0;
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
